// File: rtl/mem_resp_pkg.sv
// Shared definitions for the memory-side line responder.
// FSM encoding, line geometry defaults and the line-wrap address helper.
package mem_resp_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WAIT  = 2'd1;
  localparam logic [1:0] ST_BURST = 2'd2;

  localparam int LOG_NUM_BLOCKS_DEF = 1;
  localparam int OFF_WIDTH = LOG_NUM_BLOCKS_DEF;
  localparam int BL = 1 << LOG_NUM_BLOCKS_DEF;

  // Offset wraps inside the line; it never carries into the base.
  function automatic logic [31:0] line_wrap(
    input logic [31:0] base,
    input logic [31:0] off,
    input logic [31:0] k,
    input logic [31:0] bl
  );
    return base | ((off + k) & (bl - 32'd1));
  endfunction

endpackage

// File: rtl/mem_line_responder_array.sv
// Word storage: one synchronous write port, one enabled synchronous read port.
// Contents are intentionally not reset.
module mem_word_array #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  // Read data only moves when re is pulsed, so it holds across stalls.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/mem_line_responder.sv
// Memory-side responder: one outstanding request, fixed latency,
// wrap-around line bursts for reads and a single ack beat for writes.
module mem_line_responder
  import mem_resp_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 8,
  parameter int LOG_NUM_BLOCKS = 1,
  parameter int LATENCY        = 4,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_WIDTH-1:0] resp_data,
  output logic [ADDR_WIDTH-1:0] resp_addr,
  output logic                  resp_last,
  output logic                  busy,
  output logic [CNT_WIDTH-1:0]  rd_count,
  output logic [CNT_WIDTH-1:0]  wr_count
);

  localparam int LINE_BL = 1 << LOG_NUM_BLOCKS;
  localparam int OW = (LOG_NUM_BLOCKS > 0) ? LOG_NUM_BLOCKS : 1;
  localparam logic [ADDR_WIDTH-1:0] OFF_MASK =
    ADDR_WIDTH'(LINE_BL - 1);

  logic [1:0]            state;
  logic [7:0]            lat_cnt;
  logic [ADDR_WIDTH-1:0] cap_addr;
  logic                  cap_write;
  logic [OW-1:0]         beat;

  logic                  accept;
  logic                  hs;
  logic                  last_beat;
  logic                  wr_en;
  logic                  rd_en;
  logic [ADDR_WIDTH-1:0] cur_addr;
  logic [ADDR_WIDTH-1:0] nxt_addr;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic [31:0]           base_w;
  logic [31:0]           off_w;

  assign base_w = 32'(cap_addr & ~OFF_MASK);
  assign off_w  = 32'(cap_addr & OFF_MASK);

  assign cur_addr = ADDR_WIDTH'(line_wrap(
    base_w, off_w, 32'(beat), 32'(LINE_BL)));
  assign nxt_addr = ADDR_WIDTH'(line_wrap(
    base_w, off_w, 32'(beat) + 32'd1, 32'(LINE_BL)));

  assign accept    = (state == ST_IDLE) && req_valid;
  assign hs        = (state == ST_BURST) && resp_ready;
  assign last_beat = cap_write || (beat == OW'(LINE_BL - 1));
  assign wr_en     = accept && req_write;

  // Fetch beat 0 on the last wait cycle, later beats on each handshake.
  assign rd_en = !cap_write &&
    (((state == ST_WAIT) && (lat_cnt == 8'd0)) ||
     (hs && !last_beat));
  assign rd_addr = (state == ST_WAIT) ? cur_addr : nxt_addr;

  mem_word_array #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_array (
    .clk  (clk),
    .we   (wr_en),
    .waddr(req_addr),
    .wdata(req_wdata),
    .re   (rd_en),
    .raddr(rd_addr),
    .rdata(mem_rdata)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      lat_cnt   <= '0;
      cap_addr  <= '0;
      cap_write <= 1'b0;
      beat      <= '0;
      rd_count  <= '0;
      wr_count  <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (req_valid) begin
            state     <= ST_WAIT;
            lat_cnt   <= 8'(LATENCY - 1);
            cap_addr  <= req_addr;
            cap_write <= req_write;
            beat      <= '0;
            if (req_write) begin
              if (wr_count != '1)
                wr_count <= wr_count + CNT_WIDTH'(1);
            end else begin
              if (rd_count != '1)
                rd_count <= rd_count + CNT_WIDTH'(1);
            end
          end
        end
        ST_WAIT: begin
          if (lat_cnt == 8'd0) state <= ST_BURST;
          else lat_cnt <= lat_cnt - 8'd1;
        end
        ST_BURST: begin
          if (resp_ready) begin
            if (last_beat) state <= ST_IDLE;
            else beat <= beat + OW'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign req_ready  = (state == ST_IDLE);
  assign busy       = (state != ST_IDLE);
  assign resp_valid = (state == ST_BURST);
  assign resp_last  = resp_valid && last_beat;
  assign resp_addr  = resp_valid ? cur_addr : '0;
  assign resp_data  = (resp_valid && !cap_write) ? mem_rdata : '0;

endmodule

// File: tb/tb_mem_line_responder.sv
// Bench for mem_line_responder: transaction-level model plus directed
// literal checks and randomized traffic with backpressure and resets.
module tb_mem_line_responder;

  localparam int LAT = 4;
  localparam int BL  = 2;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [7:0]  req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_data;
  logic [7:0]  resp_addr;
  logic        resp_last;
  logic        busy;
  logic [15:0] rd_count;
  logic [15:0] wr_count;

  mem_line_responder #(
    .DATA_WIDTH(32),
    .ADDR_WIDTH(8),
    .LOG_NUM_BLOCKS(1),
    .LATENCY(LAT),
    .CNT_WIDTH(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_write(req_write),
    .req_addr(req_addr),
    .req_wdata(req_wdata),
    .resp_valid(resp_valid),
    .resp_ready(resp_ready),
    .resp_data(resp_data),
    .resp_addr(resp_addr),
    .resp_last(resp_last),
    .busy(busy),
    .rd_count(rd_count),
    .wr_count(wr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp,
               $time);
    end
  endtask

  // Transaction-level reference model
  typedef struct {
    logic [7:0]  a;
    logic [31:0] d;
    logic        l;
  } beat_t;

  beat_t       q[$];
  logic [31:0] m_mem [256];
  bit          m_busy = 0;
  bit          m_acc = 0;
  int          m_cnt = 0;
  int          m_rd = 0;
  int          m_wr = 0;

  task automatic model_reset();
    m_busy = 0;
    m_cnt = 0;
    m_rd = 0;
    m_wr = 0;
    q.delete();
  endtask

  task automatic model_step();
    m_acc = 0;
    if (!rst) return;
    if (!m_busy) begin
      if (req_valid) begin
        m_acc = 1;
        m_busy = 1;
        m_cnt = LAT;
        if (req_write) begin
          m_mem[req_addr] = req_wdata;
          q.push_back('{a: req_addr, d: 32'd0, l: 1'b1});
          if (m_wr < 65535) m_wr++;
        end else begin
          for (int k = 0; k < BL; k++) begin
            int base;
            int off;
            logic [7:0] a;
            base = (int'(req_addr) / BL) * BL;
            off = (int'(req_addr) % BL + k) % BL;
            a = 8'(base + off);
            q.push_back('{a: a, d: m_mem[a], l: (k == BL - 1)});
          end
          if (m_rd < 65535) m_rd++;
        end
      end
    end else if (m_cnt > 0) begin
      m_cnt--;
    end else if (resp_ready) begin
      beat_t b;
      b = q.pop_front();
      if (b.l) m_busy = 0;
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // Per-cycle compare against the model
  initial forever begin
    @(negedge clk);
    if (!rst) begin
      chk("rst_req_ready", 64'(req_ready), 64'(1));
      chk("rst_resp_valid", 64'(resp_valid), 64'(0));
      chk("rst_busy", 64'(busy), 64'(0));
      chk("rst_rd_count", 64'(rd_count), 64'(0));
      chk("rst_wr_count", 64'(wr_count), 64'(0));
    end else begin
      bit ev;
      ev = m_busy && (m_cnt == 0) && (q.size() > 0);
      chk("req_ready", 64'(req_ready), 64'(!m_busy));
      chk("busy", 64'(busy), 64'(m_busy));
      chk("resp_valid", 64'(resp_valid), 64'(ev));
      if (ev) begin
        chk("resp_addr", 64'(resp_addr), 64'(q[0].a));
        chk("resp_data", 64'(resp_data), 64'(q[0].d));
        chk("resp_last", 64'(resp_last), 64'(q[0].l));
      end
      chk("rd_count", 64'(rd_count), 64'(m_rd));
      chk("wr_count", 64'(wr_count), 64'(m_wr));
    end
  end

  // resp_ready: 0 = always ready, 1 = random, 2 = stalled
  int rr_mode = 0;

  initial begin
    resp_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rr_mode)
        0: resp_ready = 1'b1;
        1: resp_ready = ($urandom_range(0, 3) != 0);
        default: resp_ready = 1'b0;
      endcase
    end
  end

  task automatic send(input logic w, input logic [7:0] a,
                      input logic [31:0] d);
    int n;
    @(posedge clk);
    #1;
    req_valid = 1'b1;
    req_write = w;
    req_addr = a;
    req_wdata = d;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!m_acc && n < 300);
    if (!m_acc) chk("accept_timeout", 64'(0), 64'(1));
    req_valid = 1'b0;
  endtask

  task automatic wait_valid(output int edges);
    edges = 0;
    @(negedge clk);
    while (!resp_valid && edges < 100) begin
      @(negedge clk);
      edges++;
    end
    if (!resp_valid) chk("valid_timeout", 64'(0), 64'(1));
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (m_busy && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (m_busy) chk("idle_timeout", 64'(0), 64'(1));
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    #2;
    rst = 1'b0;
    model_reset();
    #1;
    chk("async_resp_valid", 64'(resp_valid), 64'(0));
    chk("async_req_ready", 64'(req_ready), 64'(1));
    @(negedge clk);
    #2;
    rst = 1'b1;
  endtask

  int lat;

  initial begin
    rst = 1'b0;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr = '0;
    req_wdata = '0;
    model_reset();
    #22;
    rst = 1'b1;

    // Idle after reset
    repeat (10) @(negedge clk);
    chk("idle_req_ready", 64'(req_ready), 64'(1));
    chk("idle_counts", 64'({rd_count, wr_count}), 64'(0));

    // Write ack latency and shape
    send(1'b1, 8'h12, 32'hDEADBEEF);
    wait_valid(lat);
    chk("wr_latency", 64'(lat), 64'(4));
    chk("wr_ack_addr", 64'(resp_addr), 64'h12);
    chk("wr_ack_data", 64'(resp_data), 64'h0);
    chk("wr_ack_last", 64'(resp_last), 64'(1));
    wait_idle();
    @(negedge clk);
    chk("wr_count_1", 64'(wr_count), 64'(1));

    send(1'b1, 8'h20, 32'hA);
    send(1'b1, 8'h21, 32'hB);
    send(1'b1, 8'h13, 32'h13131313);
    send(1'b1, 8'h40, 32'h4040);
    send(1'b1, 8'h41, 32'h4141);
    wait_idle();

    // Wrap-around read from the upper word
    send(1'b0, 8'h21, 32'h0);
    wait_valid(lat);
    chk("wrap_b0", 64'({resp_addr, resp_data, 7'd0, resp_last}),
        64'({8'h21, 32'hB, 8'h00}));
    @(negedge clk);
    chk("wrap_b1", 64'({resp_addr, resp_data, 7'd0, resp_last}),
        64'({8'h20, 32'hA, 8'h01}));
    wait_idle();
    @(negedge clk);
    chk("rd_count_1", 64'(rd_count), 64'(1));

    // Backpressure on beat 0
    rr_mode = 2;
    send(1'b0, 8'h21, 32'h0);
    wait_valid(lat);
    repeat (5) begin
      @(negedge clk);
      chk("stall_b0", 64'({resp_valid, resp_addr, resp_data}),
          64'({1'b1, 8'h21, 32'hB}));
    end
    rr_mode = 0;
    wait_idle();

    // Request while busy is ignored until idle
    send(1'b0, 8'h21, 32'h0);
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr = 8'h40;
    @(negedge clk);
    chk("busy_rd_count", 64'(rd_count), 64'(3));
    chk("busy_req_ready", 64'(req_ready), 64'(0));
    begin
      int n;
      n = 0;
      do begin
        @(posedge clk);
        #1;
        n++;
      end while (!m_acc && n < 300);
      if (!m_acc) chk("busy_accept_timeout", 64'(0), 64'(1));
    end
    req_valid = 1'b0;
    @(negedge clk);
    chk("busy_rd_count_after", 64'(rd_count), 64'(4));
    wait_idle();

    // Reset during a stalled beat 0
    rr_mode = 2;
    send(1'b0, 8'h21, 32'h0);
    wait_valid(lat);
    pulse_reset();
    rr_mode = 0;
    send(1'b0, 8'h12, 32'h0);
    wait_valid(lat);
    chk("post_rst_data", 64'(resp_data), 64'hDEADBEEF);
    chk("post_rst_addr", 64'(resp_addr), 64'h12);
    wait_idle();

    // Randomized traffic
    rr_mode = 1;
    for (int a = 0; a < 32; a++) send(1'b1, 8'(a), $urandom);
    wait_idle();
    for (int i = 0; i < 60; i++) begin
      send(1'($urandom_range(0, 1)), 8'($urandom_range(0, 31)),
           $urandom);
      if ($urandom_range(0, 7) == 0) begin
        repeat ($urandom_range(0, 6)) @(posedge clk);
        pulse_reset();
      end else if ($urandom_range(0, 1) == 1) begin
        wait_idle();
      end
    end
    wait_idle();
    repeat (5) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_line_responder.md
Name: mem_line_responder

Overview:
Memory-side responder for the cache hierarchy. It serves line-fill reads and write-through word writes issued by the L2 miss/update path. It holds one request outstanding at a time, models a fixed access latency, and returns a read line as a wrap-around burst, starting from the requested word, under valid/ready flow control. Backing storage is a word array of 2^ADDR_WIDTH entries.

Parameters:
DATA_WIDTH, 32, word width in bits
ADDR_WIDTH, 8, word address width; storage depth is 2^ADDR_WIDTH words
LOG_NUM_BLOCKS, 1, log2 of words per line; burst length BL = 2^LOG_NUM_BLOCKS
LATENCY, 4, cycles from request acceptance to first response beat; legal range 1..255
CNT_WIDTH, 16, width of the statistics counters

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-low (0 = reset asserted)
req_valid  in  1  request present
req_ready  out  1  responder can accept a request
req_write  in  1  1 = single-word write, 0 = line read
req_addr  in  ADDR_WIDTH  word address (critical word for reads)
req_wdata  in  DATA_WIDTH  write data
resp_valid  out  1  response beat present
resp_ready  in  1  requester accepts beat
resp_data  out  DATA_WIDTH  read word; 0 on write ack
resp_addr  out  ADDR_WIDTH  address of the current beat
resp_last  out  1  final beat of the response
busy  out  1  not IDLE
rd_count  out  CNT_WIDTH  accepted reads, saturating
wr_count  out  CNT_WIDTH  accepted writes, saturating

Behaviour:
- Reset (rst=0, async): state=IDLE; req_ready=1, resp_valid=0, resp_last=0, resp_data=0, resp_addr=0, busy=0, rd_count=0, wr_count=0. Storage contents are not cleared.
- Handshake: a transfer occurs on the rising edge where valid&&ready=1. The requester holds req_* stable while req_valid=1 && req_ready=0. resp_* hold stable while resp_valid=1 && resp_ready=0.
- req_ready=1 only in IDLE, so at most one request is outstanding.
- FSM states: IDLE, WAIT, BURST.
- IDLE -> WAIT on acceptance at edge T. Capture addr and write. Load lat_cnt=LATENCY-1. Increment the matching counter (no wrap at max).
  - Write: storage[req_addr]<=req_wdata at edge T.
- WAIT: lat_cnt decrements each cycle. When lat_cnt==0, go to BURST; the first resp_valid=1 appears in cycle T+LATENCY.
  - LATENCY=1: WAIT lasts one cycle; first beat appears in cycle T+1.
- BURST, read: beat k (k=0..BL-1) carries resp_addr = {line_base, (word_off+k) mod BL} and resp_data = storage[resp_addr].
  - The offset wraps within the line and never carries into line_base.
  - resp_last=1 on k=BL-1. The beat counter advances only on resp_valid&&resp_ready.
- BURST, write: exactly one beat with resp_last=1, resp_data=0, resp_addr=captured addr.
- On the handshake of a beat with resp_last=1, go to IDLE: req_ready=1 and resp_valid=0 in the next cycle. There is no back-to-back overlap.
- Back-to-back stall: resp_ready=0 for any duration holds state, beat index and outputs. The storage read must be registered or held so resp_data is stable.
- Read-after-write ordering is trivially preserved (single outstanding request). A read of a just-written address returns the new data.
- Reset mid-WAIT or mid-BURST aborts immediately; no further beats are produced.
  - A write accepted before reset remains in storage.
- req_valid while busy: ignored; no state change.

Decomposition:
- Shared package mem_resp_pkg:
  - FSM state encoding (IDLE/WAIT/BURST).
  - Constants BL and OFF_WIDTH=LOG_NUM_BLOCKS.
  - Function for the line-wrap address: base | ((off+k) & (BL-1)).
- One sub-module, mem_word_array: 2^ADDR_WIDTH x DATA_WIDTH, one synchronous write port, one synchronous read port with read-enable. The FSM drives the read-enable only when advancing a beat, which gives hold-on-stall.

Test Plan:
- Reset then idle: after rst release, req_ready=1, resp_valid=0, busy=0, counters=0; hold 10 cycles, no change.
- Write/ack latency: write addr 0x12 data 0xDEADBEEF, accepted at cycle T -> single beat at T+4 with resp_last=1, resp_data=0, resp_addr=0x12; wr_count=1.
- Wrap burst: preload 0x20=0xA, 0x21=0xB; read addr 0x21 -> beat0 {0x21,0xB}, beat1 {0x20,0xA, last=1}; rd_count=1.
- Backpressure: same read with resp_ready=0 for 5 cycles on beat0 -> beat0 held stable; after release, beat1 follows and req_ready returns the cycle after last.
- Busy rejection: second req_valid during WAIT with addr 0x40 -> not accepted, counters unchanged; it is accepted in IDLE after the first response completes.
- Reset mid-burst: assert rst during beat0 stall -> resp_valid=0 immediately (async), state IDLE; the earlier write at 0x12 still reads 0xDEADBEEF.
